// File: rtl/float_adder_fp32.sv
// IEEE-754 single-precision adder/subtractor, one-cycle registered latency.
// Define FLOAT_ADDER_RNE_EN for round-to-nearest-even; the default build truncates.
module float_adder_fp32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] Out,
    output logic [24:0] Out_test,
    output logic [7:0]  shift,
    output logic        c_out
);

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic [7:0]  ea, eb, eL, eS;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb, mL, mS, al;
    logic        sL, sS;
    logic [7:0]  shift_d;
    logic [24:0] sum_d;
    logic [4:0]  lz;
    logic [23:0] mant;
    logic [9:0]  exp_n;
    logic        is_zero;
    logic [31:0] norm;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [31:0] out_d;
`ifdef FLOAT_ADDER_RNE_EN
    logic [49:0] wide;
    logic        g, r, st, rnd;
    logic [27:0] ext;
    logic [26:0] m27;
    logic [24:0] mant25;
`endif

    logic        valid_q;
    logic [31:0] out_q;
    logic [24:0] test_q;
    logic [7:0]  shift_q;

    always_comb begin
        ea = a[30:23];
        eb = b[30:23];
        fa = (ea == 8'd0) ? 23'd0 : a[22:0];
        fb = (eb == 8'd0) ? 23'd0 : b[22:0];
        ma = {ea != 8'd0, fa};
        mb = {eb != 8'd0, fb};

        // Ties in magnitude keep a as the large operand.
        if ({ea, fa} >= {eb, fb}) begin
            sL = a[31]; sS = b[31]; eL = ea; eS = eb; mL = ma; mS = mb;
        end else begin
            sL = b[31]; sS = a[31]; eL = eb; eS = ea; mL = mb; mS = ma;
        end
        shift_d = eL - eS;
        lz      = 5'd0;
        mant    = 24'd0;
        exp_n   = 10'd0;

`ifdef FLOAT_ADDER_RNE_EN
        wide = {mS, 26'd0} >> shift_d;
        if (shift_d >= 8'd26) begin
            al = 24'd0; g = 1'b0; r = 1'b0; st = |mS;
        end else begin
            al = wide[49:26]; g = wide[25]; r = wide[24]; st = |wide[23:0];
        end
        sum_d = (sL == sS) ? ({1'b0, mL} + {1'b0, al}) : ({1'b0, mL} - {1'b0, al});
        ext   = (sL == sS) ? ({1'b0, mL, 3'b000} + {1'b0, al, g, r, st})
                           : ({1'b0, mL, 3'b000} - {1'b0, al, g, r, st});
        if (ext[27]) begin
            m27   = {ext[27:2], ext[1] | ext[0]};
            exp_n = {2'b00, eL} + 10'd1;
        end else begin
            lz    = lzc27(ext[26:0]);
            m27   = ext[26:0] << lz;
            exp_n = {2'b00, eL} - {5'd0, lz};
        end
        rnd    = m27[2] & (m27[1] | m27[0] | m27[3]);
        mant25 = {1'b0, m27[26:3]} + {24'd0, rnd};
        if (mant25[24]) begin
            mant  = mant25[24:1];
            exp_n = exp_n + 10'd1;
        end else begin
            mant  = mant25[23:0];
        end
`else
        al    = mS >> shift_d;
        sum_d = (sL == sS) ? ({1'b0, mL} + {1'b0, al}) : ({1'b0, mL} - {1'b0, al});
        if (sum_d[24]) begin
            mant  = sum_d[24:1];
            exp_n = {2'b00, eL} + 10'd1;
        end else begin
            lz    = lzc27({sum_d[23:0], 3'b000});
            mant  = sum_d[23:0] << lz;
            exp_n = {2'b00, eL} - {5'd0, lz};
        end
`endif

        // A normalised non-zero mantissa always has its top bit set.
        is_zero = !mant[23];
        if (is_zero)
            norm = 32'd0;
        else if (!exp_n[9] && exp_n >= 10'd255)
            norm = {sL, 8'hFF, 23'd0};
        else if (exp_n[9] || exp_n == 10'd0)
            norm = {sL, 31'd0};
        else
            norm = {sL, exp_n[7:0], mant[22:0]};

        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            out_d = 32'h7FC00000;
        else if (a_inf)
            out_d = a;
        else if (b_inf)
            out_d = b;
        else
            out_d = norm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= 32'd0;
            test_q  <= 25'd0;
            shift_q <= 8'd0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q   <= out_d;
                test_q  <= sum_d;
                shift_q <= shift_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign Out       = out_q;
    assign Out_test  = test_q;
    assign shift     = shift_q;
    assign c_out     = test_q[24];

endmodule

// File: tb/tb_float_adder_fp32.sv
// Self-checking bench for float_adder_fp32 (default truncating build):
// directed vectors plus randomised operands against an arithmetic reference model.
module tb_float_adder_fp32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic [31:0] Out;
    logic [24:0] Out_test;
    logic [7:0]  shift;
    logic        c_out;

    int checks = 0;
    int errors = 0;

    float_adder_fp32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .Out(Out), .Out_test(Out_test),
        .shift(shift), .c_out(c_out)
    );

    always #5 clk = ~clk;

    // Reference: {Out, Out_test, shift, c_out} computed with plain integer arithmetic.
    function automatic logic [65:0] model(input logic [31:0] x, input logic [31:0] y);
        longint ex, ey, fx, fy, mx, my, eL, eS, mL, mS, al, ot, m, e, sh;
        logic sL, sS;
        logic [31:0] res;
        ex = longint'(x[30:23]);
        ey = longint'(y[30:23]);
        fx = (ex == 0) ? 0 : longint'(x[22:0]);
        fy = (ey == 0) ? 0 : longint'(y[22:0]);
        mx = (ex == 0) ? 0 : fx + 'h800000;
        my = (ey == 0) ? 0 : fy + 'h800000;
        if (ex * 'h800000 + fx >= ey * 'h800000 + fy) begin
            sL = x[31]; sS = y[31]; eL = ex; eS = ey; mL = mx; mS = my;
        end else begin
            sL = y[31]; sS = x[31]; eL = ey; eS = ex; mL = my; mS = mx;
        end
        sh = eL - eS;
        al = (sh >= 24) ? 0 : mS / (longint'(1) << sh);
        ot = (sL == sS) ? mL + al : mL - al;
        if (ot == 0) begin
            res = 32'd0;
        end else begin
            m = ot;
            e = eL;
            while (m >= 'h1000000) begin m = m / 2; e++; end
            while (m < 'h800000) begin m = m * 2; e--; end
            if (e >= 255)     res = {sL, 8'hFF, 23'd0};
            else if (e <= 0)  res = {sL, 31'd0};
            else              res = {sL, 8'(e), 23'(m - 'h800000)};
        end
        if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
            (ex == 255 && ey == 255 && x[31] != y[31]))
            res = 32'h7FC00000;
        else if (ex == 255)
            res = x;
        else if (ey == 255)
            res = y;
        return {res, 25'(ot), 8'(sh), ot >= 'h1000000};
    endfunction

    task automatic gen(output logic [31:0] x, output logic [31:0] y);
        logic [31:0] sp [8];
        int mode;
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
               32'h7FC00000, 32'h7F7FFFFF, 32'h00000001, 32'h3F800000};
        mode = $urandom_range(0, 3);
        x = $urandom;
        y = $urandom;
        case (mode)
            1: y = {1'($urandom), 8'(x[30:23] + 8'($urandom_range(0, 2))),
                    x[22:0] ^ 23'($urandom & 32'h3F)};
            2: begin
                x[30:23] = 8'($urandom_range(100, 150));
                y[30:23] = 8'($urandom_range(100, 150));
            end
            3: begin
                if ($urandom_range(0, 1) == 1) x = sp[$urandom_range(0, 7)];
                y = sp[$urandom_range(0, 7)];
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, Out, Out_test, shift, c_out} !== 67'd0) begin
            errors++;
            $display("FAIL reset: got valid=%0b Out=%h test=%h shift=%0d c=%0b, expected all 0",
                     out_valid, Out, Out_test, shift, c_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] vo [10];
        logic [24:0] vt [10];
        logic [7:0]  vs [10];
        logic        vc [10];
        va = '{32'hBF800000, 32'h3F800000, 32'h40400000, 32'h40400000, 32'h7F800000,
               32'h7F7FFFFF, 32'h3F800000, 32'h7F800001, 32'hFF800000, 32'h80800001};
        vb = '{32'hC0600000, 32'h40400000, 32'hBF800000, 32'hC0400000, 32'hFF800000,
               32'h7F7FFFFF, 32'h00000001, 32'h3F800000, 32'h3F800000, 32'h00800000};
        vo = '{32'hC0900000, 32'h40800000, 32'h40000000, 32'h00000000, 32'h7FC00000,
               32'h7F800000, 32'h3F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
        vt = '{25'h1200000, 25'h1000000, 25'h0800000, 25'h0, 25'h0,
               25'h1FFFFFE, 25'h0800000, 25'h0800001, 25'h0800000, 25'h1};
        vs = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd127, 8'd128, 8'd128, 8'd0};
        vc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({out_valid, Out, Out_test, shift, c_out} !== {1'b1, vo[i], vt[i], vs[i], vc[i]}) begin
                errors++;
                $display("FAIL directed[%0d] a=%h b=%h: got valid=%0b Out=%h test=%h shift=%0d c=%0b, expected Out=%h test=%h shift=%0d c=%0b",
                         i, va[i], vb[i], out_valid, Out, Out_test, shift, c_out,
                         vo[i], vt[i], vs[i], vc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic [65:0] exp_q;
        for (int i = 0; i <= 400; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({out_valid, Out, Out_test, shift, c_out} !== {1'b1, exp_q}) begin
                    errors++;
                    $display("FAIL random[%0d]: got valid=%0b Out=%h test=%h shift=%0d c=%0b, expected Out=%h test=%h shift=%0d c=%0b",
                             i - 1, out_valid, Out, Out_test, shift, c_out,
                             exp_q[65:34], exp_q[33:9], exp_q[8:1], exp_q[0]);
                end
            end
            if (i < 400) begin
                gen(x, y);
                a = x; b = y; in_valid = 1'b1;
                exp_q = model(x, y);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] x, y;
        logic [65:0] held;
        gen(x, y);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        held = model(x, y);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom; b = $urandom;
            checks++;
            if ({out_valid, Out, Out_test, shift, c_out} !== {(i == 0), held}) begin
                errors++;
                $display("FAIL hold[%0d]: got valid=%0b Out=%h test=%h, expected valid=%0b Out=%h test=%h",
                         i, out_valid, Out, Out_test, (i == 0), held[65:34], held[33:9]);
            end
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, Out, Out_test, shift, c_out} !== 67'd0) begin
            errors++;
            $display("FAIL reset_midop: got valid=%0b Out=%h test=%h shift=%0d, expected all 0",
                     out_valid, Out, Out_test, shift);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, Out, Out_test, shift, c_out} !== 67'd0) begin
            errors++;
            $display("FAIL reset_discard: got valid=%0b Out=%h test=%h, expected all 0",
                     out_valid, Out, Out_test);
        end
        a = 32'h40400000; b = 32'hBF800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, Out} !== {1'b1, 32'h40000000}) begin
            errors++;
            $display("FAIL reset_recover: got valid=%0b Out=%h, expected valid=1 Out=40000000",
                     out_valid, Out);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
